// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the serial feeder and the downstream sequence checker:
// state encoding, counter sizing and the checker's target pattern.
package seq_serializer_pkg;

  localparam logic IDLE_CODE  = 1'b0;
  localparam logic SHIFT_CODE = 1'b1;

  typedef enum logic {
    IDLE  = IDLE_CODE,
    SHIFT = SHIFT_CODE
  } state_e;

  // 6-bit pattern the checker fed by dout looks for, first-received bit in [5].
  localparam logic [5:0] CHECKER_PATTERN = 6'b100110;

  // Bit-counter width for a word of w bits (w is at least 2, so never zero).
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder: valid/ready word input, one-word holding buffer,
// registered serial output advanced by a bit-rate strobe.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int   DATA_W    = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bit_en,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int              CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_e              state, state_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic [DATA_W-1:0]   hold_data, hold_data_n;
  logic                hold_vld, hold_vld_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                dout_n, dout_valid_n, frame_start_n;
  logic                accept, last_bit;

  function automatic logic lead_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  // While rst is high nothing may transfer; the buffer gates acceptance otherwise.
  assign in_ready = !rst && !hold_vld;
  assign accept   = in_valid && in_ready;
  assign last_bit = (state == SHIFT) && bit_en && (cnt == LAST_CNT);
  assign busy     = (state == SHIFT) || hold_vld;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    hold_data_n = hold_data;
    hold_vld_n  = hold_vld;

    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_n = in_data;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          cnt_n = '0;
          if (hold_vld) begin
            shreg_n    = hold_data;
            hold_vld_n = 1'b0;
          end else if (accept) begin
            shreg_n = in_data;
          end else begin
            state_n = IDLE;
          end
        end else if (bit_en) begin
          shreg_n = shift_once(shreg);
          cnt_n   = cnt + 1'b1;
        end
        // A word taken at a last-bit edge with an empty buffer went straight
        // to the shifter above; any other accepted word parks in the buffer.
        if (accept && !(last_bit && !hold_vld)) begin
          hold_data_n = in_data;
          hold_vld_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    dout_valid_n  = (state_n == SHIFT);
    dout_n        = dout_valid_n ? lead_bit(shreg_n) : IDLE_BIT;
    frame_start_n = dout_valid_n && (cnt_n == '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state       <= IDLE;
      hold_vld    <= 1'b0;
      cnt         <= '0;
      dout        <= IDLE_BIT;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      hold_vld    <= hold_vld_n;
      cnt         <= cnt_n;
      dout        <= dout_n;
      dout_valid  <= dout_valid_n;
      frame_start <= frame_start_n;
    end
  end

  // NOTE: data-only registers carry no reset; their contents are ignored until
  // the state/valid flags that qualify them are set by a load.
  always_ff @(posedge clk) begin
    shreg     <= shreg_n;
    hold_data <= hold_data_n;
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench: directed tables, multi-cycle corner sequences and a
// randomized run against a queue-based model of the word stream.
module tb_seq_serializer;
  import seq_serializer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       bit_en = 1'b1;
  logic       in_ready, dout, dout_valid, frame_start, busy;

  logic [7:0] b_in_data = '0;
  logic       b_in_valid = 1'b0;
  logic       b_bit_en = 1'b1;
  logic       b_in_ready, b_dout, b_dout_valid, b_frame_start, b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_serializer #(.DATA_W(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bit_en(bit_en), .dout(dout), .dout_valid(dout_valid),
    .frame_start(frame_start), .busy(busy)
  );

  seq_serializer #(.DATA_W(8), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .bit_en(b_bit_en), .dout(b_dout), .dout_valid(b_dout_valid),
    .frame_start(b_frame_start), .busy(b_busy)
  );

  // Reference model for the MSB-first instance: a queue of words in flight
  // (head is on the wire) plus the index of the bit currently shown.
  logic [7:0] mq[$];
  int         mpos = 0;

  always @(posedge clk) begin
    bit acc;
    acc = in_valid && !rst && (mq.size() < 2);
    if (rst) begin
      mq.delete();
      mpos = 0;
    end else begin
      if (bit_en && mq.size() > 0) begin
        mpos++;
        if (mpos == 8) begin
          void'(mq.pop_front());
          mpos = 0;
        end
      end
      if (acc) mq.push_back(in_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [7:0] w;
    logic       ev, eb, ef;
    ev = mq.size() > 0;
    eb = 1'b0;
    if (ev) begin
      w  = mq[0];
      eb = w[7-mpos];
    end
    ef = ev && (mpos == 0);
    check("model_dout",        32'(dout),        32'(eb));
    check("model_dout_valid",  32'(dout_valid),  32'(ev));
    check("model_frame_start", 32'(frame_start), 32'(ef));
    check("model_busy",        32'(busy),        32'(ev));
    check("model_in_ready",    32'(in_ready),    32'(!rst && mq.size() < 2));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 200) begin
      tick();
      c++;
    end
    check("idle_timeout", 32'(busy), 32'(0));
  endtask

  typedef struct {
    bit         lsb;
    logic       v;
    logic [7:0] d;
    logic       e_dout;
    logic       e_dv;
    logic       e_fs;
  } vec_t;

  vec_t vecs[$];

  task automatic add_word_vecs(input bit lsb, input logic [7:0] w, input logic idle_lvl);
    vec_t r;
    for (int i = 0; i < 10; i++) begin
      r.lsb    = lsb;
      r.v      = (i == 0);
      r.d      = w;
      r.e_dv   = (i < 8);
      r.e_fs   = (i == 0);
      r.e_dout = (i < 8) ? (lsb ? w[i] : w[7-i]) : idle_lvl;
      vecs.push_back(r);
    end
  endtask

  initial begin
    // Reset: in_ready held low while rst is high, outputs idle after the edge.
    rst = 1'b1;
    tick();
    check("rst_dout",        32'(dout),        32'(0));
    check("rst_dout_valid",  32'(dout_valid),  32'(0));
    check("rst_frame_start", 32'(frame_start), 32'(0));
    check("rst_busy",        32'(busy),        32'(0));
    check("rst_in_ready",    32'(in_ready),    32'(0));
    check("rst_b_dout",      32'(b_dout),      32'(1));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));

    // Table-driven single words: 9A MSB-first, 01 LSB-first idling high.
    add_word_vecs(1'b0, 8'h9A, 1'b0);
    add_word_vecs(1'b1, 8'h01, 1'b1);
    foreach (vecs[k]) begin
      if (vecs[k].lsb) begin
        b_in_valid = vecs[k].v;
        b_in_data  = vecs[k].d;
      end else begin
        in_valid = vecs[k].v;
        in_data  = vecs[k].d;
      end
      tick();
      if (vecs[k].lsb) begin
        check("vec_b_dout", 32'(b_dout),        32'(vecs[k].e_dout));
        check("vec_b_dv",   32'(b_dout_valid),  32'(vecs[k].e_dv));
        check("vec_b_fs",   32'(b_frame_start), 32'(vecs[k].e_fs));
      end else begin
        check("vec_dout", 32'(dout),        32'(vecs[k].e_dout));
        check("vec_dv",   32'(dout_valid),  32'(vecs[k].e_dv));
        check("vec_fs",   32'(frame_start), 32'(vecs[k].e_fs));
      end
    end
    check("vec_idle_busy", 32'(busy), 32'(0));

    // Back-to-back words with in_valid held: 24 contiguous bits.
    begin
      logic [7:0]  w[3];
      logic [23:0] got = '0;
      int idx = 0, nv = 0, gaps = 0, saw_nr = 0;
      int fs_pos[$];
      bit acc;
      w[0] = 8'h26; w[1] = 8'hFF; w[2] = 8'h00;
      in_valid = 1'b1;
      in_data  = w[0];
      for (int c = 0; c < 40; c++) begin
        acc = in_ready;
        tick();
        if (acc) begin
          idx++;
          if (idx < 3) in_data = w[idx];
          else in_valid = 1'b0;
        end
        if (in_valid && !in_ready) saw_nr++;
        if (dout_valid) begin
          if (frame_start) fs_pos.push_back(nv);
          got = {got[22:0], dout};
          nv++;
        end else if (nv > 0 && nv < 24) begin
          gaps++;
        end
      end
      check("b2b_bits",     32'(nv),   32'(24));
      check("b2b_gaps",     32'(gaps), 32'(0));
      check("b2b_stream",   32'(got),  32'h0026FF00);
      check("b2b_fs_count", 32'(fs_pos.size()), 32'(3));
      if (fs_pos.size() == 3) begin
        check("b2b_fs1", 32'(fs_pos[1]), 32'(8));
        check("b2b_fs2", 32'(fs_pos[2]), 32'(16));
      end
      check("b2b_ready_drop", 32'(saw_nr > 0), 32'(1));
    end
    wait_idle();

    // Slow bit rate: each bit held 3 cycles; a second word buffered mid-stall.
    begin
      logic [23:0] s = '0;
      logic [7:0]  w = 8'hA5;
      in_valid = 1'b1;
      in_data  = w;
      bit_en   = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 24; k++) begin
        s[23-k] = dout;
        bit_en  = (k % 3 == 2);
        if (k == 4) begin
          in_valid = 1'b1;
          in_data  = 8'h3C;
        end
        tick();
        if (k == 4) begin
          in_valid = 1'b0;
          check("stall_buf_ready", 32'(in_ready), 32'(0));
          check("stall_buf_busy",  32'(busy),     32'(1));
        end
      end
      for (int i = 0; i < 8; i++)
        check($sformatf("stall_bit%0d", i), 32'(s[23-3*i -: 3]), 32'({3{w[7-i]}}));
      bit_en = 1'b1;
    end
    wait_idle();

    // Reset during bit 3 of C3 with 5A buffered: both words are dropped.
    begin
      int nv = 0;
      in_valid = 1'b1;
      in_data  = 8'hC3;
      tick();
      in_data  = 8'h5A;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("abort_bit3",   32'(dout),     32'(0));
      check("abort_hold",   32'(in_ready), 32'(0));
      rst = 1'b1;
      tick();
      check("abort_dout",  32'(dout),       32'(0));
      check("abort_dv",    32'(dout_valid), 32'(0));
      check("abort_busy",  32'(busy),       32'(0));
      rst = 1'b0;
      #1;
      check("abort_ready", 32'(in_ready), 32'(1));
      for (int c = 0; c < 20; c++) begin
        tick();
        if (dout_valid) nv++;
      end
      check("abort_silent", 32'(nv), 32'(0));
    end

    // Feed to the checker: 8'h98 holds the target pattern once, ending at bit 6.
    begin
      logic [7:0] bits = '0;
      int hits = 0, hit_end = -1;
      in_valid = 1'b1;
      in_data  = 8'h98;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        bits[7-i] = dout;
        tick();
      end
      for (int e = 5; e < 8; e++) begin
        if (bits[7-e+5 -: 6] == CHECKER_PATTERN) begin
          hits++;
          hit_end = e;
        end
      end
      check("chk_hits",    32'(hits),    32'(1));
      check("chk_hit_end", 32'(hit_end), 32'(5));
    end
    wait_idle();

    // Randomized traffic, bit-rate and occasional reset against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = 8'($urandom);
      bit_en   = ($urandom_range(0, 9) < 6);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    bit_en   = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Upstream feeder for the serial sequence checker: converts parallel words into a one-bit-per-step serial stream on `dout`.
- `dout` connects directly to the checker's `din`.
- Words arrive over a valid/ready handshake.
- A one-word holding buffer allows back-to-back words to be serialized with no idle bits between them.
- A bit-rate enable allows the stream to be slowed below clock rate.

Parameters:
- DATA_W, 8, word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = transmit bit DATA_W-1 first; 0 = transmit bit 0 first.
- IDLE_BIT, 1'b0, level driven on `dout` when no word is being serialized.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- in_data  in  DATA_W  parallel word to serialize.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word this cycle.
- bit_en  in  1  shift strobe; the serial stream advances only on edges where bit_en=1.
- dout  out  1  serial data (to checker din).
- dout_valid  out  1  dout carries a word bit.
- frame_start  out  1  high while dout carries the first bit of a word.
- busy  out  1  a word is in the shifter or the holding buffer.

Behaviour:
- Reset (rst high at an edge): after that edge, dout=IDLE_BIT, dout_valid=0, frame_start=0, busy=0, state=IDLE, holding buffer empty, bit counter=0.
- While rst=1, in_ready=0 and no transfer occurs.
- A reset asserted mid-word aborts the word; the remaining bits are never emitted.
- Transfer: a word is accepted on an edge where in_valid & in_ready. Otherwise in_ready = !hold_vld.
- States:
  - IDLE: shifter empty. An accepted word loads straight into the shifter at the accepting edge (bypassing the holding buffer); state becomes SHIFT.
  - SHIFT: shifter holds the current word. The bit counter counts 0..DATA_W-1 and advances only when bit_en=1.
- Output timing:
  - dout, dout_valid and frame_start are registered; there is no combinational path from inputs to them.
  - A word loaded into the shifter is first presented after the loading edge.
  - Each bit stays on dout until the next edge where bit_en=1.
  - frame_start=1 exactly while bit counter=0 in SHIFT.
- Bit order: bits are emitted from MSB to LSB when MSB_FIRST=1, and from LSB to MSB otherwise.
- Last bit (counter=DATA_W-1 with bit_en=1):
  - Holding buffer full: load the buffered word into the shifter, counter=0, stay in SHIFT, clear hold_vld. There is no gap.
  - Buffer empty and a word accepted at the same edge: load that word directly into the shifter. There is no gap.
  - Otherwise: go to IDLE; dout returns to IDLE_BIT and dout_valid=0 after that edge.
- Holding buffer: in SHIFT, an accepted word goes to the buffer, except in the direct-load case above. At most one word is buffered. When the buffer is full, in_ready=0 until it drains at the next last-bit edge.
- bit_en=0: shifter, counter and outputs hold. Words can still be accepted into the holding buffer, or into the shifter if the block is in IDLE.
- busy = (state==SHIFT) | hold_vld.
- Throughput: one bit per bit_en pulse, sustained indefinitely when in_valid stays high.

Decomposition:
- Shared header: localparams for the state encoding (IDLE=1'b0, SHIFT=1'b1) and the counter width (clog2 of DATA_W).
- The same header also holds the checker's 6-bit target pattern, so benches can build stimulus for the serializer and checker together.
- Single module; the logic is small enough that no sub-module is warranted.

Test Plan:
- DATA_W=8, MSB_FIRST=1, bit_en=1; push 8'h9A at edge N -> dout = 1,0,0,1,1,0,1,0 during cycles N+1..N+8; dout_valid high for exactly those 8 cycles; frame_start high only at N+1; then dout=0, dout_valid=0, busy=0.
- Back-to-back words 8'h26, 8'hFF, 8'h00 with in_valid held high -> 24 contiguous valid bits with no gap; in_ready drops to 0 while the buffer is full; frame_start pulses at bit 0, 8 and 16.
- Chain with the sequence checker: push 8'b1001_1000 -> checker success_flag asserts once, the cycle after bit 6 is shifted in.
- bit_en pattern 1,0,0,1,... while serializing 8'hA5 -> each bit is held 3 cycles; the bit order is unchanged; a second word pushed during the stall is accepted into the buffer and in_ready=0 afterwards.
- rst pulsed for one cycle during bit 3 of 8'hC3, with a word buffered -> after the reset edge dout=IDLE_BIT, dout_valid=0, busy=0, in_ready=1; the buffered word is discarded and never emitted.
- MSB_FIRST=0, IDLE_BIT=1; push 8'h01 -> dout = 1,0,0,0,0,0,0,0, then idles at 1.
